// File: rtl/mips32_fetch_queue_if.sv
// Fetch-queue bus: instruction memory read port, EX redirect, and decode-side delivery.
interface mips32_fetch_queue_if #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [ADDR_W-1:0] if_npc;
    logic              if_ready;
    logic              halted;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc,
        output if_valid, if_instr, if_npc,
        input  if_ready,
        output halted, occupancy
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc,
        input  if_valid, if_instr, if_npc,
        output if_ready,
        input  halted, occupancy
    );
endinterface

// File: rtl/mips32_fetch_queue.sv
// MIPS32 instruction prefetch queue: one-cycle-latency imem reads into a small FIFO,
// with EX redirect flush and HLT-driven drain/halt.
module mips32_fetch_queue #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input logic               clk,
    input logic               rst_n,
    mips32_fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_addr;
    logic              inflight;
    logic [31:0]       q_instr [DEPTH];
    logic [ADDR_W-1:0] q_npc   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [OCC_W-1:0]  occ, occ_nx;
    logic              req, valid, enq, deq, hlt_in;

    // Returned data is only accepted in RUN; anything arriving in DRAIN/HALTED or
    // alongside a redirect belongs to a squashed read.
    assign enq    = inflight && (state == RUN) && !bus.redirect_valid;
    assign hlt_in = enq && (bus.imem_rdata[31:26] == 6'h3F);
    assign deq    = valid && bus.if_ready;

    always_comb begin
        occ_nx = occ;
        if (enq && !deq)
            occ_nx = occ + OCC_W'(1);
        else if (deq && !enq)
            occ_nx = occ - OCC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.redirect_valid) begin
            state_nx = RUN;
        end else begin
            case (state)
                RUN:     if (hlt_in) state_nx = DRAIN;
                DRAIN:   if (occ_nx == '0) state_nx = HALTED;
                HALTED:  state_nx = HALTED;
                default: state_nx = RUN;
            endcase
        end
    end

    always_comb begin
        req   = 1'b0;
        valid = 1'b0;
        case (state)
            RUN: begin
                // Count in-flight reads so a returning word always has a free slot.
                req   = rst_n && !bus.redirect_valid && ((occ + OCC_W'(inflight)) < DEPTH_C);
                valid = (occ != '0);
            end
            DRAIN:   valid = (occ != '0);
            default: begin
                req   = 1'b0;
                valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc            <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
        end else if (bus.redirect_valid) begin
            pc            <= bus.redirect_pc;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
        end else begin
            if (req)
                pc <= pc + ADDR_W'(1);
            inflight      <= req;
            inflight_addr <= pc;
            if (enq)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq)
                rd_ptr <= rd_ptr + PTR_W'(1);
            occ <= occ_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && enq) begin
            q_instr[wr_ptr] <= bus.imem_rdata;
            q_npc[wr_ptr]   <= inflight_addr + ADDR_W'(1);
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc;
    assign bus.if_valid  = valid;
    // Gate the head so an empty queue never exposes stale entries.
    assign bus.if_instr  = valid ? q_instr[rd_ptr] : '0;
    assign bus.if_npc    = valid ? q_npc[rd_ptr]   : '0;
    assign bus.halted    = (state == HALTED);
    assign bus.occupancy = occ;
endmodule

// File: doc/mips32_fetch_queue.md
MIPS32_FETCH_QUEUE -- requirements
Module: mips32_fetch_queue

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the word-address width of the PC and instruction memory.
REQ-002 Parameter DEPTH, default 4, SHALL set prefetch queue entries (power of two, 2..16).
REQ-003 clk  input  1  SHALL be the single clock; the block has one clock and all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 imem_req  output  1  SHALL be the instruction memory read strobe.
REQ-006 imem_addr  output  ADDR_W  SHALL be the word address of the read.
REQ-007 imem_rdata  input  32  SHALL be the read data, valid exactly one cycle after imem_req.
REQ-008 redirect_valid  input  1  SHALL request a fetch redirect (taken branch from EX).
REQ-009 redirect_pc  input  ADDR_W  SHALL be the redirect target word address.
REQ-010 if_valid  output  1  SHALL flag a valid instruction at the queue head.
REQ-011 if_instr  output  32  SHALL be the head instruction word.
REQ-012 if_npc  output  ADDR_W  SHALL be the head instruction's address plus 1, modulo 2^ADDR_W.
REQ-013 if_ready  input  1  SHALL be the decode-stage accept.
REQ-014 halted  output  1  SHALL flag the HALTED state.
REQ-015 occupancy  output  clog2(DEPTH)+1  SHALL be the number of valid queue entries.

Function
REQ-016 States SHALL be RUN, DRAIN, HALTED.
REQ-017 In RUN, imem_req SHALL assert when occupancy plus in-flight reads is less than DEPTH and redirect_valid is low; imem_addr = fetch PC; fetch PC increments by 1 per request, wrapping from 2^ADDR_W-1 to 0.
REQ-018 Returned data SHALL be enqueued, tagged with its address, on the cycle it is valid unless squashed; no bypass, so the first if_valid appears 2 cycles after the first request.
REQ-019 A handshake SHALL occur when if_valid and if_ready are both high; the head is dequeued at that edge.
REQ-020 Enqueue and dequeue in the same cycle SHALL leave occupancy unchanged; the queue SHALL never overflow or present stale data when empty.
REQ-021 An enqueued word with bits[31:26] = 6'h3F (HLT) SHALL move RUN->DRAIN, stop new requests, and squash any read still in flight.
REQ-022 In DRAIN, the HLT word SHALL be delivered normally; when the queue becomes empty the state SHALL move to HALTED with halted = 1.
REQ-023 In HALTED, imem_req and if_valid SHALL stay 0.
REQ-024 redirect_valid SHALL, from any state: flush the queue (occupancy 0 next cycle), squash in-flight reads, load fetch PC with redirect_pc, enter RUN, and clear halted. The first request to redirect_pc issues the following cycle.
REQ-025 Redirect SHALL take priority over a same-cycle handshake, enqueue or HLT detection; a word accepted in that cycle counts as delivered.
REQ-026 if_instr and if_npc SHALL be held stable while if_valid is high and if_ready is low.

Reset
REQ-027 While rst_n = 0 at a rising edge: fetch PC = 0, queue empty, in-flight cleared, state RUN, imem_req = 0, imem_addr = 0, if_valid = 0, if_instr = 0, if_npc = 0, halted = 0, occupancy = 0.
REQ-028 Reset asserted mid-operation SHALL discard all queued and in-flight data; the first request after release SHALL be to address 0.

Verification
REQ-029 Memory words 0..8 = 2801000A, 28020014, 28030019, 0CE77800, 0CE77800, 00222000, 0CE77800, 00832800, FC000000, with if_ready = 1 -> words delivered in order with if_npc 1..9, then halted = 1, and no request beyond address 9.
REQ-030 if_ready = 0 for 10 cycles after reset -> occupancy saturates at DEPTH (4), imem_req deasserts, and the head is held at 2801000A with if_npc = 1.
REQ-031 redirect_valid with redirect_pc = 5 while 3 entries are queued -> occupancy = 0 next cycle; the next delivered word is 00222000 with if_npc = 6.
REQ-032 Redirect to 0 while HALTED -> halted = 0 next cycle and the program replays from 2801000A.
REQ-033 Fetch PC at 1023 -> the next request is to address 0; if_npc of the word at 1023 = 0.
REQ-034 rst_n = 0 for 1 cycle with the queue full -> all outputs at REQ-027 values, then the request to address 0 resumes.
